// File: rtl/e203_ifu_flush_redirect_if.sv
// ----------------------------------------------------------------------------
// e203_ifu_flush_redirect_if
// Bundles every signal between the flush sources, the redirect stage and the
// IFU PC generator.
//   slave  : view taken by the redirect stage (requests in, acks/redirect out)
//   master : view taken by the flush sources / IFU model driving the stage
// Signals:
//   brchmis_flush_req/ack, brchmis_flush_add_op1/op2 : branch-class flush
//   excp_flush_req/ack, excp_flush_pc                : exception/irq flush
//   ifu_redirect_valid/ready/pc/src                  : redirect toward IFU
//   ifu_fetch_halt                                   : stop new fetches
//   brchmis_cnt, excp_cnt                            : saturating event counts
// ----------------------------------------------------------------------------
interface e203_ifu_flush_redirect_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
);
    logic             brchmis_flush_req;
    logic             brchmis_flush_ack;
    logic [PC_W-1:0]  brchmis_flush_add_op1;
    logic [PC_W-1:0]  brchmis_flush_add_op2;
    logic             excp_flush_req;
    logic             excp_flush_ack;
    logic [PC_W-1:0]  excp_flush_pc;
    logic             ifu_redirect_valid;
    logic             ifu_redirect_ready;
    logic [PC_W-1:0]  ifu_redirect_pc;
    logic             ifu_redirect_src;
    logic             ifu_fetch_halt;
    logic [CNT_W-1:0] brchmis_cnt;
    logic [CNT_W-1:0] excp_cnt;

    modport slave (
        input  brchmis_flush_req, brchmis_flush_add_op1, brchmis_flush_add_op2,
        input  excp_flush_req, excp_flush_pc, ifu_redirect_ready,
        output brchmis_flush_ack, excp_flush_ack,
        output ifu_redirect_valid, ifu_redirect_pc, ifu_redirect_src,
        output ifu_fetch_halt, brchmis_cnt, excp_cnt
    );

    modport master (
        output brchmis_flush_req, brchmis_flush_add_op1, brchmis_flush_add_op2,
        output excp_flush_req, excp_flush_pc, ifu_redirect_ready,
        input  brchmis_flush_ack, excp_flush_ack,
        input  ifu_redirect_valid, ifu_redirect_pc, ifu_redirect_src,
        input  ifu_fetch_halt, brchmis_cnt, excp_cnt
    );
endinterface

// File: rtl/e203_ifu_flush_redirect.sv
// ----------------------------------------------------------------------------
// e203_ifu_flush_redirect
// One-entry registered redirect buffer between the commit-side flush sources
// and the IFU PC generator. Exception flushes win over branch flushes; the
// captured target is offered to the IFU over valid/ready, fetch is halted
// while a redirect is outstanding, and two saturating counters record the
// accepted flushes of each kind.
// Ports:
//   clk      : core clock
//   rst_n    : asynchronous active-low reset
//   flush_if : e203_ifu_flush_redirect_if.slave (all request/redirect signals)
// ----------------------------------------------------------------------------
module e203_ifu_flush_redirect #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    e203_ifu_flush_redirect_if.slave       flush_if
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_e;

    state_e            r_state;
    logic [PC_W-1:0]   r_pc;
    logic              r_src;
    logic [CNT_W-1:0]  r_brchmis_cnt;
    logic [CNT_W-1:0]  r_excp_cnt;

    logic              w_pend;
    logic              w_slot_free;
    logic              w_excp_hs;
    logic              w_brch_hs;
    logic [PC_W-1:0]   w_brch_sum;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] res;
        if (&val) begin
            res = val;
        end else begin
            res = val + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    // Slot availability, priority arbitration and target adder.
    // A redirect taken by the IFU this cycle frees the slot in the same cycle,
    // which is what allows one redirect per cycle with ready held high.
    always_comb begin
        w_pend      = 1'b0;
        w_slot_free = 1'b0;
        w_excp_hs   = 1'b0;
        w_brch_hs   = 1'b0;
        w_brch_sum  = {PC_W{1'b0}};
        if (r_state == ST_PEND) begin
            w_pend = 1'b1;
        end else begin
            w_pend = 1'b0;
        end
        w_slot_free = ~w_pend | flush_if.ifu_redirect_ready;
        w_excp_hs   = flush_if.excp_flush_req & w_slot_free;
        w_brch_hs   = flush_if.brchmis_flush_req & w_slot_free & ~flush_if.excp_flush_req;
        // Carry out of the MSB is intentionally dropped.
        w_brch_sum  = flush_if.brchmis_flush_add_op1 + flush_if.brchmis_flush_add_op2;
    end

    // Acks and halt are combinational so upstream sees them in the request cycle.
    always_comb begin
        flush_if.excp_flush_ack    = w_slot_free;
        flush_if.brchmis_flush_ack = w_slot_free & ~flush_if.excp_flush_req;
        flush_if.ifu_fetch_halt    = w_pend | flush_if.brchmis_flush_req | flush_if.excp_flush_req;
    end

    // Redirect state and output registers; pc/src hold while pending and not taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= {PC_W{1'b0}};
            r_src   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_PEND: begin
                    if (w_excp_hs) begin
                        r_state <= ST_PEND;
                        r_pc    <= {flush_if.excp_flush_pc[PC_W-1:1], 1'b0};
                        r_src   <= 1'b1;
                    end else if (w_brch_hs) begin
                        r_state <= ST_PEND;
                        r_pc    <= {w_brch_sum[PC_W-1:1], 1'b0};
                        r_src   <= 1'b0;
                    end else if (w_pend & flush_if.ifu_redirect_ready) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= r_state;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Per-source accepted-flush counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_brchmis_cnt <= {CNT_W{1'b0}};
            r_excp_cnt    <= {CNT_W{1'b0}};
        end else begin
            if (w_brch_hs) begin
                r_brchmis_cnt <= sat_inc(r_brchmis_cnt);
            end else begin
                r_brchmis_cnt <= r_brchmis_cnt;
            end
            if (w_excp_hs) begin
                r_excp_cnt <= sat_inc(r_excp_cnt);
            end else begin
                r_excp_cnt <= r_excp_cnt;
            end
        end
    end

    // Drive the registered redirect and counter outputs.
    always_comb begin
        flush_if.ifu_redirect_valid = w_pend;
        flush_if.ifu_redirect_pc    = r_pc;
        flush_if.ifu_redirect_src   = r_src;
        flush_if.brchmis_cnt        = r_brchmis_cnt;
        flush_if.excp_cnt           = r_excp_cnt;
    end

endmodule

// File: tb/tb_e203_ifu_flush_redirect.sv
// ----------------------------------------------------------------------------
// tb_e203_ifu_flush_redirect
// Drives a full-width instance and a CNT_W=2 instance with identical stimulus
// and compares both against a queue-based reference of the redirect rules.
// ----------------------------------------------------------------------------
module tb_e203_ifu_flush_redirect;

    logic clk;
    logic rst_n;

    e203_ifu_flush_redirect_if #(.PC_W(32), .CNT_W(32)) bif ();
    e203_ifu_flush_redirect_if #(.PC_W(32), .CNT_W(2))  sif ();

    e203_ifu_flush_redirect #(.PC_W(32), .CNT_W(32)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_if (bif.slave)
    );

    e203_ifu_flush_redirect #(.PC_W(32), .CNT_W(2)) u_dut_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_if (sif.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        src;
    } redir_t;

    redir_t      m_q[$];
    logic [31:0] m_last_pc;
    logic        m_last_src;
    longint      m_bcnt;
    longint      m_ecnt;

    int n_chk;
    int n_pass;

    // Single comparison point: counts and reports mismatches.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint sat3(input longint v);
        return (v > 3) ? 64'd3 : v;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_last_pc  = 32'h0;
        m_last_src = 1'b0;
        m_bcnt     = 0;
        m_ecnt     = 0;
    endtask

    task automatic drive(input logic breq, input logic [31:0] op1, input logic [31:0] op2,
                         input logic ereq, input logic [31:0] epc, input logic rdy);
        bif.brchmis_flush_req     = breq;  sif.brchmis_flush_req     = breq;
        bif.brchmis_flush_add_op1 = op1;   sif.brchmis_flush_add_op1 = op1;
        bif.brchmis_flush_add_op2 = op2;   sif.brchmis_flush_add_op2 = op2;
        bif.excp_flush_req        = ereq;  sif.excp_flush_req        = ereq;
        bif.excp_flush_pc         = epc;   sif.excp_flush_pc         = epc;
        bif.ifu_redirect_ready    = rdy;   sif.ifu_redirect_ready    = rdy;
    endtask

    // Compare all observable outputs against the reference state.
    task automatic check_outputs(input logic breq, input logic ereq, input logic rdy);
        bit pending;
        bit free;
        pending = (m_q.size() != 0);
        free    = !pending || rdy;
        chk("excp_ack",  bif.excp_flush_ack, free);
        chk("brch_ack",  bif.brchmis_flush_ack, free && !ereq);
        chk("halt",      bif.ifu_fetch_halt, pending || breq || ereq);
        chk("valid",     bif.ifu_redirect_valid, pending);
        chk("pc",        bif.ifu_redirect_pc, m_last_pc);
        chk("src",       bif.ifu_redirect_src, m_last_src);
        chk("bcnt",      bif.brchmis_cnt, m_bcnt);
        chk("ecnt",      bif.excp_cnt, m_ecnt);
        chk("sat_valid", sif.ifu_redirect_valid, pending);
        chk("sat_bcnt",  sif.brchmis_cnt, sat3(m_bcnt));
        chk("sat_ecnt",  sif.excp_cnt, sat3(m_ecnt));
    endtask

    // One clock cycle: drive after the falling edge, check, then advance the model.
    task automatic step(input logic breq, input logic [31:0] op1, input logic [31:0] op2,
                        input logic ereq, input logic [31:0] epc, input logic rdy);
        bit free;
        redir_t e;
        @(negedge clk);
        drive(breq, op1, op2, ereq, epc, rdy);
        #1;
        check_outputs(breq, ereq, rdy);
        free = (m_q.size() == 0) || rdy;
        if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
        if (ereq && free) begin
            e.pc  = epc & 32'hFFFF_FFFE;
            e.src = 1'b1;
            m_q.push_back(e);
            m_last_pc = e.pc; m_last_src = e.src;
            m_ecnt = m_ecnt + 1;
        end else if (breq && free) begin
            e.pc  = (op1 + op2) & 32'hFFFF_FFFE;
            e.src = 1'b0;
            m_q.push_back(e);
            m_last_pc = e.pc; m_last_src = e.src;
            m_bcnt = m_bcnt + 1;
        end
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, rdy);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        model_reset();
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", bif.ifu_redirect_valid, 1'b0);
        chk("rst_pc",    bif.ifu_redirect_pc, 32'h0);
        chk("rst_src",   bif.ifu_redirect_src, 1'b0);
        chk("rst_eack",  bif.excp_flush_ack, 1'b1);
        chk("rst_back",  bif.brchmis_flush_ack, 1'b1);
        chk("rst_halt",  bif.ifu_fetch_halt, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Branch redirect
        step(1'b1, 32'h8000_0100, 32'h0000_0004, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("br_pc",   bif.ifu_redirect_pc, 32'h8000_0104);
        chk("br_halt", bif.ifu_fetch_halt, 1'b1);
        idle(1'b0);
        chk("br_done", bif.ifu_redirect_valid, 1'b0);
        chk("br_cnt",  bif.brchmis_cnt, 32'd1);

        // Priority: both requests together
        step(1'b1, 32'h1000, 32'h20, 1'b1, 32'h8000_0041, 1'b0);
        idle(1'b0);
        chk("pri_pc",   bif.ifu_redirect_pc, 32'h8000_0040);
        chk("pri_src",  bif.ifu_redirect_src, 1'b1);
        chk("pri_ecnt", bif.excp_cnt, 32'd1);
        chk("pri_bcnt", bif.brchmis_cnt, 32'd1);

        // Backpressure: pending, ready low for three cycles with a branch waiting
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h0000_2000, 32'h0000_0010, 1'b0, 32'h0, 1'b0);
            chk("bp_ack", bif.brchmis_flush_ack, 1'b0);
            chk("bp_pc",  bif.ifu_redirect_pc, 32'h8000_0040);
        end
        step(1'b1, 32'h0000_2000, 32'h0000_0010, 1'b0, 32'h0, 1'b1);
        idle(1'b0);
        chk("bb_valid", bif.ifu_redirect_valid, 1'b1);
        chk("bb_pc",    bif.ifu_redirect_pc, 32'h0000_2010);

        // Adder wrap
        step(1'b1, 32'hFFFF_FFFE, 32'h0000_0004, 1'b0, 32'h0, 1'b1);
        idle(1'b0);
        chk("wrap_pc", bif.ifu_redirect_pc, 32'h0000_0002);

        // Asynchronous reset while pending with counters nonzero
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", bif.ifu_redirect_valid, 1'b0);
        chk("ar_pc",    bif.ifu_redirect_pc, 32'h0);
        chk("ar_bcnt",  bif.brchmis_cnt, 32'h0);
        chk("ar_ecnt",  bif.excp_cnt, 32'h0);
        model_reset();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) idle(1'b0);

        // Saturation on the 2-bit instance: five back-to-back branch flushes
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 32'h100 * i, 32'h8, 1'b0, 32'h0, 1'b1);
        end
        idle(1'b1);
        chk("sat_stop", sif.brchmis_cnt, 2'd3);
        chk("sat_full", bif.brchmis_cnt, 32'd5);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0, $urandom, $urandom,
                 ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0, $urandom,
                 ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0);
        end
        idle(1'b1);
        idle(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
